// File: rtl/ifm_feed_pkg.sv
// Shared definitions for the IFM stream feeder: map size codes, padded
// geometry helpers and the frame FSM state type.
package ifm_feed_pkg;

    localparam int unsigned SEL_W = 3;
    // Wide enough for the largest padded dimension (450).
    localparam int unsigned DIM_W = 9;

    localparam logic [SEL_W-1:0] SEL_14  = 3'd0;
    localparam logic [SEL_W-1:0] SEL_28  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_56  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_112 = 3'd3;
    localparam logic [SEL_W-1:0] SEL_224 = 3'd4;
    localparam logic [SEL_W-1:0] SEL_448 = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } feed_state_t;

    // True for a size code the linebuffer supports.
    function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
        return sel <= SEL_448;
    endfunction

    // Unpadded map width W for a size code.
    function automatic logic [DIM_W-1:0] map_width(input logic [SEL_W-1:0] sel);
        logic [DIM_W-1:0] w;
        case (sel)
            SEL_14:  w = 9'd14;
            SEL_28:  w = 9'd28;
            SEL_56:  w = 9'd56;
            SEL_112: w = 9'd112;
            SEL_224: w = 9'd224;
            SEL_448: w = 9'd448;
            default: w = 9'd14;
        endcase
        return w;
    endfunction

    // Padded dimension P = W + 2; equals the linebuffer's cumulative segment
    // length for the same code (16/30/58/114/226/450).
    function automatic logic [DIM_W-1:0] pad_len(input logic [SEL_W-1:0] sel);
        return map_width(sel) + DIM_W'(2);
    endfunction

endpackage

// File: rtl/ifm_stream_feeder_if.sv
// Bus bundle between the IFM feeder, its controller, the BRAM port and the
// linebuffer / PE array. master = feeder side, slave = everything around it.
interface ifm_stream_feeder_if
    import ifm_feed_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);

    // Frame control
    logic              start;
    logic [SEL_W-1:0]  sel_cfg;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic              cfg_err;

    // Linebuffer size select
    logic [SEL_W-1:0]  sel_out;

    // BRAM read port
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // Stream and window qualifiers
    logic [DATA_W-1:0] pix_out;
    logic              win_valid;
    logic              win_last;

    modport master (
        input  start, sel_cfg, base_addr, mem_rdata,
        output busy, done, cfg_err, sel_out,
        output mem_rd_en, mem_addr, pix_out, win_valid, win_last
    );

    modport slave (
        output start, sel_cfg, base_addr, mem_rdata,
        input  busy, done, cfg_err, sel_out,
        input  mem_rd_en, mem_addr, pix_out, win_valid, win_last
    );

endinterface

// File: rtl/ifm_stream_feeder_pad_raster_counter.sv
// Row/column raster counter over the padded P x P map. Holds the position
// that will be issued next and classifies it.
module pad_raster_counter
    import ifm_feed_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_step,
    input  logic [DIM_W-1:0] i_pad_len,
    output logic             o_interior,
    output logic             o_win_pos,
    output logic             o_last
);

    logic [DIM_W-1:0] r_row;
    logic [DIM_W-1:0] r_col;
    logic [DIM_W-1:0] w_edge;
    logic             w_col_end;
    logic             w_row_end;

    assign w_edge    = i_pad_len - DIM_W'(1);
    assign w_col_end = (r_col == w_edge);
    assign w_row_end = (r_row == w_edge);

    // Advance column fastest, wrap into the next row at the padded edge.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_step) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + DIM_W'(1);
            end else begin
                r_col <= r_col + DIM_W'(1);
            end
        end
    end

    // Classify the current position: real pixel, window-complete, frame end.
    always_comb begin
        o_interior = (r_row != '0) && (r_row != w_edge) &&
                     (r_col != '0) && (r_col != w_edge);
        o_win_pos  = (r_row >= DIM_W'(2)) && (r_col >= DIM_W'(2));
        o_last     = w_row_end && w_col_end;
    end

endmodule

// File: rtl/ifm_stream_feeder.sv
// IFM stream feeder: reads one square channel from BRAM and emits a
// zero-padded raster stream into the 3x3 linebuffer, with window
// qualifiers aligned to the linebuffer's win3_3 register.
module ifm_stream_feeder
    import ifm_feed_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    ifm_stream_feeder_if.master bus
);

    feed_state_t       r_state;
    feed_state_t       w_state_nxt;

    logic              w_accept;
    logic              w_reject;
    logic              w_issue;
    logic              w_clear;
    logic [DIM_W-1:0]  w_pad_len;

    logic              w_interior;
    logic              w_win_pos;
    logic              w_last;

    logic [SEL_W-1:0]  r_sel_out;
    logic              r_cfg_err;

    // Issue stage (visible one cycle after the position is issued)
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_run_addr;
    logic              r_pad_d1;
    logic              r_win_d1;
    logic              r_last_d1;

    // Delay pipeline
    logic              r_pad_d2;
    logic              r_win_d2;
    logic              r_win_d3;
    logic              r_last_d2;
    logic              r_last_d3;
    logic [DATA_W-1:0] r_pix;
    logic              r_win_valid;
    logic              r_win_last;
    logic              r_done;

    // The counter must already obey the new size on the accepting edge,
    // before sel_out has been updated.
    assign w_pad_len = (r_state == IDLE) ? pad_len(bus.sel_cfg) : pad_len(r_sel_out);

    pad_raster_counter u_raster (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_step     (w_issue),
        .i_pad_len  (w_pad_len),
        .o_interior (w_interior),
        .o_win_pos  (w_win_pos),
        .o_last     (w_last)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (w_last)   w_state_nxt = DRAIN;
            DRAIN:   if (r_done)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs. Position (0,0) is issued on the accepting edge itself so
    // that its registered read controls appear in the first busy cycle;
    // RUN then issues one further position per edge up to and including
    // the last one.
    always_comb begin
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_issue  = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = bus.start && sel_valid(bus.sel_cfg);
                w_reject = bus.start && !sel_valid(bus.sel_cfg);
                w_issue  = w_accept;
            end
            RUN:     w_issue = 1'b1;
            default: w_issue = 1'b0;
        endcase
        w_clear = !w_issue;
    end

    // Frame configuration: size select latch and bad-code pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_out <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_reject;
            if (w_accept) begin
                r_sel_out <= bus.sel_cfg;
            end
        end
    end

    // Issue stage: BRAM request for interior positions, running address,
    // and first-stage pad/window flags. Non-issue cycles look like pad.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_en    <= 1'b0;
            r_mem_addr <= '0;
            r_run_addr <= '0;
            r_pad_d1   <= 1'b1;
            r_win_d1   <= 1'b0;
            r_last_d1  <= 1'b0;
        end else begin
            r_rd_en   <= w_issue && w_interior;
            r_pad_d1  <= !(w_issue && w_interior);
            r_win_d1  <= w_issue && w_win_pos;
            r_last_d1 <= w_issue && w_last;
            // (0,0) is always pad, so loading base never collides with a read.
            if (w_accept) begin
                r_run_addr <= bus.base_addr;
            end else if (w_issue && w_interior) begin
                r_mem_addr <= r_run_addr;
                r_run_addr <= r_run_addr + ADDR_W'(1);
            end
        end
    end

    // Delay pipeline: pixel mux on BRAM return, window flags aligned to win3_3.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pad_d2    <= 1'b1;
            r_win_d2    <= 1'b0;
            r_win_d3    <= 1'b0;
            r_last_d2   <= 1'b0;
            r_last_d3   <= 1'b0;
            r_pix       <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_pad_d2    <= r_pad_d1;
            r_win_d2    <= r_win_d1;
            r_win_d3    <= r_win_d2;
            r_last_d2   <= r_last_d1;
            r_last_d3   <= r_last_d2;
            r_pix       <= r_pad_d2 ? '0 : bus.mem_rdata;
            r_win_valid <= r_win_d3;
            r_win_last  <= r_last_d3;
            r_done      <= r_win_last;
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.sel_out   = r_sel_out;
    assign bus.mem_rd_en = r_rd_en;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.pix_out   = r_pix;
    assign bus.win_valid = r_win_valid;
    assign bus.win_last  = r_win_last;

endmodule

// File: tb/tb_ifm_stream_feeder.sv
// Self-checking bench for ifm_stream_feeder: table-driven frames with fixed
// expectations, hand-written corner sequences, and random frames checked
// cycle by cycle against a positional reference model.
module tb_ifm_stream_feeder;

    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifm_stream_feeder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ifm_stream_feeder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] mem_seed = 8'h00;

    // BRAM contents; seed 0 gives (addr & 0xFF).
    function automatic logic [7:0] bram(input logic [15:0] a, input logic [7:0] s);
        return a[7:0] ^ (s & a[15:8]) ^ {s[3:0], s[7:4]};
    endfunction

    // BRAM with one-cycle read latency; garbage when not reading.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_rd_en ? bram(bus.mem_addr, mem_seed) : 8'hA5;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (positional arithmetic) -------------
    function automatic int width_of(input int sel);
        int w_tab[6] = '{14, 28, 56, 112, 224, 448};
        return w_tab[sel];
    endfunction

    function automatic bit is_interior(input int p, input int n);
        int r = n / p;
        int c = n % p;
        return (r >= 1) && (r <= p - 2) && (c >= 1) && (c <= p - 2);
    endfunction

    function automatic bit is_win(input int p, input int n);
        return ((n / p) >= 2) && ((n % p) >= 2);
    endfunction

    function automatic logic [15:0] addr_of(input int p, input int n, input logic [15:0] base);
        int r = n / p;
        int c = n % p;
        return 16'(int'(base) + (r - 1) * (p - 2) + (c - 1));
    endfunction

    typedef struct {
        int         first_rd;
        logic [15:0] first_addr;
        logic [15:0] last_addr;
        int         first_win;
        int         last_win;
        int         done_cyc;
        int         win_cnt;
        int         rd_cnt;
        logic [7:0] probe_v;
    } stat_t;

    typedef struct {
        int         sel;
        logic [15:0] base;
        int         first_rd;
        logic [15:0] first_addr;
        logic [15:0] last_addr;
        int         first_win;
        int         last_win;
        int         done_cyc;
        int         win_cnt;
        int         probe_t;
        logic [7:0] probe_v;
    } vec_t;

    // Start a frame in the current cycle (cycle 0) and check every cycle
    // through the first idle cycle. Optional ignored start at mid_start and
    // reset assertion at abort_at.
    task automatic run_frame(input int sel, input logic [15:0] base, input int mid_start,
                             input int abort_at, input int probe_t, output stat_t st);
        int p  = width_of(sel) + 2;
        int pp = p * p;
        int n;
        logic        e_rd, e_win, e_last;
        logic [7:0]  e_pix;
        st = '{first_rd: -1, first_addr: '0, last_addr: '0, first_win: -1, last_win: -1,
               done_cyc: -1, win_cnt: 0, rd_cnt: 0, probe_v: '0};
        bus.sel_cfg   = 3'(sel);
        bus.base_addr = base;
        bus.start     = 1'b1;
        for (int t = 1; t <= pp + 5; t++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (abort_at > 0 && t == abort_at + 1) begin
                rst = 1'b0;
                check("rst busy",      32'(bus.busy),      0);
                check("rst mem_rd_en", 32'(bus.mem_rd_en), 0);
                check("rst mem_addr",  32'(bus.mem_addr),  0);
                check("rst win_valid", 32'(bus.win_valid), 0);
                check("rst win_last",  32'(bus.win_last),  0);
                check("rst pix_out",   32'(bus.pix_out),   0);
                check("rst sel_out",   32'(bus.sel_out),   0);
                check("rst done",      32'(bus.done),      0);
                for (int g = 0; g < 20; g++) begin
                    @(posedge clk); #1;
                    check($sformatf("post-rst done@%0d", g), 32'(bus.done), 0);
                    check($sformatf("post-rst pix@%0d", g),  32'(bus.pix_out), 0);
                end
                return;
            end
            n    = t - 1;
            e_rd = (n < pp) && is_interior(p, n);
            check($sformatf("mem_rd_en@%0d", t), 32'(bus.mem_rd_en), 32'(e_rd));
            if (e_rd) check($sformatf("mem_addr@%0d", t), 32'(bus.mem_addr), 32'(addr_of(p, n, base)));
            n     = t - 3;
            e_pix = (n >= 0 && n < pp && is_interior(p, n)) ? bram(addr_of(p, n, base), mem_seed) : 8'h00;
            check($sformatf("pix_out@%0d", t), 32'(bus.pix_out), 32'(e_pix));
            n      = t - 4;
            e_win  = (n >= 0) && (n < pp) && is_win(p, n);
            e_last = (n == pp - 1);
            check($sformatf("win_valid@%0d", t), 32'(bus.win_valid), 32'(e_win));
            check($sformatf("win_last@%0d", t),  32'(bus.win_last),  32'(e_last));
            check($sformatf("done@%0d", t),      32'(bus.done),      32'(t == pp + 4));
            check($sformatf("busy@%0d", t),      32'(bus.busy),      32'(t <= pp + 4));
            check($sformatf("cfg_err@%0d", t),   32'(bus.cfg_err),   0);
            check($sformatf("sel_out@%0d", t),   32'(bus.sel_out),   32'(sel));
            if (bus.mem_rd_en === 1'b1) begin
                if (st.first_rd < 0) begin
                    st.first_rd   = t;
                    st.first_addr = bus.mem_addr;
                end
                st.last_addr = bus.mem_addr;
                st.rd_cnt++;
            end
            if (bus.win_valid === 1'b1) begin
                if (st.first_win < 0) st.first_win = t;
                st.win_cnt++;
            end
            if (bus.win_last === 1'b1) st.last_win = t;
            if (bus.done === 1'b1)     st.done_cyc = t;
            if (t == probe_t)          st.probe_v = bus.pix_out;
            if (t == mid_start) begin
                bus.start     = 1'b1;
                bus.sel_cfg   = 3'($urandom_range(0, 7));
                bus.base_addr = ~base;
            end
            if (t == abort_at) rst = 1'b1;
        end
    endtask

    task automatic check_stats(input vec_t v, input stat_t st);
        check("first_rd cycle", 32'(st.first_rd),   32'(v.first_rd));
        check("first_rd addr",  32'(st.first_addr), 32'(v.first_addr));
        check("last_rd addr",   32'(st.last_addr),  32'(v.last_addr));
        check("first_win",      32'(st.first_win),  32'(v.first_win));
        check("win_last cycle", 32'(st.last_win),   32'(v.last_win));
        check("done cycle",     32'(st.done_cyc),   32'(v.done_cyc));
        check("win_valid count", 32'(st.win_cnt),   32'(v.win_cnt));
        check("mem_rd_en count", 32'(st.rd_cnt),    32'(v.win_cnt));
        check("probe pix",      32'(st.probe_v),    32'(v.probe_v));
    endtask

    vec_t  tab[4];
    stat_t st;

    initial begin
        tab[0] = '{sel: 0, base: 16'h0100, first_rd: 18, first_addr: 16'h0100, last_addr: 16'h01C3,
                   first_win: 38, last_win: 259, done_cyc: 260, win_cnt: 196, probe_t: 37, probe_v: 8'h0F};
        tab[1] = '{sel: 1, base: 16'h2000, first_rd: 32, first_addr: 16'h2000, last_addr: 16'h230F,
                   first_win: 66, last_win: 903, done_cyc: 904, win_cnt: 784, probe_t: 65, probe_v: 8'h1D};
        tab[2] = '{sel: 2, base: 16'hFFF0, first_rd: 60, first_addr: 16'hFFF0, last_addr: 16'h0C2F,
                   first_win: 122, last_win: 3367, done_cyc: 3368, win_cnt: 3136, probe_t: 121, probe_v: 8'h29};
        tab[3] = '{sel: 3, base: 16'h0040, first_rd: 116, first_addr: 16'h0040, last_addr: 16'h313F,
                   first_win: 234, last_win: 12999, done_cyc: 13000, win_cnt: 12544, probe_t: 233, probe_v: 8'hB1};

        // Reset state
        rst = 1'b1;
        bus.start = 1'b0;
        bus.sel_cfg = '0;
        bus.base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",      32'(bus.busy),      0);
        check("reset done",      32'(bus.done),      0);
        check("reset cfg_err",   32'(bus.cfg_err),   0);
        check("reset mem_rd_en", 32'(bus.mem_rd_en), 0);
        check("reset mem_addr",  32'(bus.mem_addr),  0);
        check("reset pix_out",   32'(bus.pix_out),   0);
        check("reset sel_out",   32'(bus.sel_out),   0);
        check("reset win_valid", 32'(bus.win_valid), 0);
        check("reset win_last",  32'(bus.win_last),  0);
        rst = 1'b0;

        // Table frames, back to back; the first has an ignored start at cycle 100.
        for (int unsigned i = 0; i < 4; i++) begin
            mem_seed = 8'h00;
            run_frame(tab[i].sel, tab[i].base, (i == 0) ? 100 : 0, 0, tab[i].probe_t, st);
            check_stats(tab[i], st);
        end

        // Bad size codes: pulse cfg_err, no frame, sel_out keeps the last code (3).
        for (int unsigned bad = 6; bad <= 7; bad++) begin
            bus.sel_cfg = 3'(bad);
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            check($sformatf("cfg_err sel=%0d", bad), 32'(bus.cfg_err), 1);
            check("cfg_err busy",    32'(bus.busy),    0);
            check("cfg_err sel_out", 32'(bus.sel_out), 3);
            for (int g = 0; g < 8; g++) begin
                @(posedge clk); #1;
                check($sformatf("cfg_err clear@%0d", g), 32'(bus.cfg_err), 0);
                check($sformatf("cfg_err rd@%0d", g),    32'(bus.mem_rd_en), 0);
                check($sformatf("cfg_err busy@%0d", g),  32'(bus.busy), 0);
                check($sformatf("cfg_err sel@%0d", g),   32'(bus.sel_out), 3);
            end
        end

        // Reset mid-frame, then a fresh scenario-1 frame.
        run_frame(1, 16'h0500, 0, 120, 0, st);
        run_frame(tab[0].sel, tab[0].base, 0, 0, tab[0].probe_t, st);
        check_stats(tab[0], st);

        // Random frames with random data, base and an ignored start.
        for (int k = 0; k < 4; k++) begin
            int sel = int'($urandom_range(0, 2));
            int w   = width_of(sel);
            int gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                check("gap busy", 32'(bus.busy), 0);
                check("gap pix",  32'(bus.pix_out), 0);
            end
            mem_seed = 8'($urandom);
            run_frame(sel, 16'($urandom), int'($urandom_range(1, (w + 2) * (w + 2) + 4)), 0, 0, st);
            check("rand win count", 32'(st.win_cnt), 32'(w * w));
            check("rand rd count",  32'(st.rd_cnt),  32'(w * w));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ifm_stream_feeder.md
Name: ifm_stream_feeder

Overview:
Producer side of the 3x3 line-buffer path. It reads one square feature-map channel from on-chip BRAM and emits a zero-padded raster stream, one pixel per clock with no gaps, into the 6-size linebuffer. It also drives that linebuffer's size select. It generates win_valid/win_last aligned to the cycle the linebuffer's 3x3 window register holds a legal convolution position, so the downstream PE array knows which windows to consume.

Parameters:
ADDR_W, 16, BRAM word address width
DATA_W, 8, pixel width; must match linebuffer stream width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle frame request; sampled only when idle
sel_cfg  in  3  map size code: 0..5 -> W = 14, 28, 56, 112, 224, 448
base_addr  in  ADDR_W  BRAM address of pixel (0,0) of the map
busy  out  1  frame in progress
done  out  1  one-cycle pulse at end of frame
cfg_err  out  1  one-cycle pulse when start is rejected for a bad sel_cfg
sel_out  out  3  linebuffer size select; latched at accepted start, held until next accepted start
mem_rd_en  out  1  BRAM read enable, registered
mem_addr  out  ADDR_W  BRAM read address, registered
mem_rdata  in  DATA_W  BRAM data; valid exactly 1 cycle after mem_rd_en
pix_out  out  DATA_W  pixel stream to linebuffer ifmstream_in; registered
win_valid  out  1  the linebuffer's 3x3 window is a legal output position this cycle
win_last  out  1  qualifies the final win_valid of the frame

Behaviour:
- Reset values: busy, done, cfg_err, mem_rd_en, win_valid, win_last all 0. mem_addr 0, pix_out 0, sel_out 0. FSM in IDLE.
- FSM states:
  - IDLE --start && sel_cfg<=5--> RUN.
  - IDLE --start && sel_cfg>5--> IDLE, with cfg_err pulsed next cycle; sel_out is unchanged.
  - RUN --last position issued--> DRAIN.
  - DRAIN --pipeline empty (done cycle)--> IDLE.
- start while busy is ignored; no queueing.
- Padded geometry: P = W+2. Raster counters are row r and col c, each 0..P-1, with col incrementing fastest. One position is issued per cycle in RUN.
- Position issue: accepted start at cycle 0 -> position (0,0) is issued at cycle 1. Position index n is issued at cycle n+1.
- Interior test: 1<=r<=W and 1<=c<=W. Interior issue sets mem_rd_en=1 and mem_addr=running address. The running address starts at base_addr and increments by 1 after each interior issue; no multiplier is used. Pad issue sets mem_rd_en=0 and holds mem_addr.
- pix_out: a position issued at cycle k appears on pix_out at cycle k+2. The value is mem_rdata for interior positions and 0 for pad positions, using a pad flag delayed 2 stages.
- win_valid: asserted at cycle k+3 for a position with r>=2 and c>=2. This is the cycle the linebuffer's win3_3 holds that pixel. The window centre maps to map pixel (r-2, c-2).
- win_last: asserted together with win_valid for position (P-1, P-1).
- Per frame: exactly W*W win_valid pulses and W*W mem_rd_en cycles.
- Outside a frame, pix_out is 0. The linebuffer free-runs, so zeros shift in.
- done: pulsed one cycle after win_last. busy is high from cycle 1 through the done cycle inclusive, and low the cycle after.
- Back-to-back frames: start may be accepted the cycle after busy falls. sel_out updates the cycle after start is accepted.
- rst mid-frame: immediate return to reset values next edge. No done pulse. In-flight BRAM data is discarded.
- Address wrap: the running address wraps modulo 2^ADDR_W silently. Bounds are the caller's responsibility.

Decomposition:
- Shared package ifm_feed_pkg holds:
  - constants SEL_14..SEL_448 = 0..5
  - function map_width(sel) returning W
  - function pad_len(sel) returning W+2; the cumulative linebuffer segment lengths 16/30/58/114/226/450 must equal this value
  - the FSM state enum IDLE/RUN/DRAIN
- One sub-module, pad_raster_counter, contains:
  - the r/c counters against P
  - outputs interior, win_pos (r>=2 && c>=2) and last
  - inputs clear and step
- Top level holds the FSM, address counter and the 2/3-stage delay pipelines.

Test Plan:
- Reset, then sel_cfg=0, base_addr=0x100, start at cycle 0:
  - mem_rd_en first at cycle 18 with addr 0x100; last at addr 0x1C3.
  - first win_valid at cycle 38.
  - win_last at 259, done at 260.
  - exactly 196 win_valid; busy high for cycles 1..260.
- Same run, BRAM holding value (addr & 0xFF):
  - pix_out = 0 on all 60 pad positions (rows 0/15, cols 0/15).
  - pix_out at cycle 37 (position (2,2)) equals 0x0F, the data at addr 0x10F.
- start with sel_cfg=6 -> cfg_err=1 at cycle 1; busy stays 0; sel_out keeps its prior value; no mem_rd_en.
- start pulsed again at cycle 100 of a sel=0 frame -> ignored. The frame completes unchanged; a second start at cycle 261 is accepted with new sel_cfg=1 (P=30, 784 win_valid).
- rst asserted at cycle 120 of a sel=1 frame -> next cycle busy=0, mem_rd_en=0, win_valid=0, pix_out=0, sel_out=0, and no done pulse. A fresh start then behaves as in scenario 1.
- sel_cfg=5 with base_addr=0xFFF0 -> 200704 win_valid and 202500 pix cycles; the address wraps to 0x0000 after 0xFFFF.
